// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx : 8N1 serial transmitter, LSB first, single clock domain.
//
// A byte is accepted into a one-deep holding register through a valid/ready
// handshake. The frame engine pulls the byte from the holding register into
// its shift register and emits start bit, eight data bits and stop bit.
// Each bit lasts CLKS_PER_BIT clock cycles. Because the holding register
// can be refilled while a frame is in flight, frames can be chained with no
// idle gap between them.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//
// Ports
//   clk     : system clock, all state changes on its rising edge
//   rst_n   : synchronous active-low reset
//   data_in : byte to transmit, sampled only on an accepting edge
//   valid   : data_in is valid
//   ready   : holding register empty (accept on valid && ready)
//   tx      : serial line, idles high, registered
//   busy    : frame in progress or holding register full
//   done    : one-cycle pulse after the last stop-bit cycle
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Registered state
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       hold_r;
  logic             hold_full_r;
  logic             tx_r;
  logic             busy_r;
  logic             done_r;
  logic             ready_r;

  // Next-state values
  logic [1:0]       state_s;
  logic [CNT_W-1:0] cnt_s;
  logic [2:0]       bit_idx_s;
  logic [7:0]       shift_s;
  logic [7:0]       hold_s;
  logic             hold_full_s;
  logic             tx_s;
  logic             busy_s;
  logic             done_s;
  logic             ready_s;
  logic             accept_s;
  logic             take_s;
  logic             bit_last_s;

  // Line level for a given frame position: high in IDLE/STOP, low in START,
  // the indexed shift-register bit in DATA.
  function automatic logic line_level(input logic [1:0] st,
                                      input logic [7:0] sh,
                                      input logic [2:0] idx);
    logic lvl;
    case (st)
      ST_IDLE:  lvl = 1'b1;
      ST_START: lvl = 1'b0;
      ST_DATA:  lvl = sh[idx];
      ST_STOP:  lvl = 1'b1;
      default:  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  // ready_r always mirrors !hold_full_r outside reset, so it is a safe accept
  // qualifier; it is also cleared by reset, which keeps ready low in reset.
  assign accept_s   = valid & ready_r;
  assign bit_last_s = (cnt_r == CNT_LAST);

  // Next-state logic: frame sequencing, bit-period counting and holding
  // register handshake. Take and accept are mutually exclusive because a take
  // needs hold_full_r = 1, which holds ready_r low.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_idx_s   = bit_idx_r;
    shift_s     = shift_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    done_s      = 1'b0;
    take_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (hold_full_r) begin
          take_s  = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (bit_last_s) begin
          cnt_s     = {CNT_W{1'b0}};
          bit_idx_s = 3'd0;
          state_s   = ST_DATA;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_DATA: begin
        if (bit_last_s) begin
          cnt_s = {CNT_W{1'b0}};
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_STOP: begin
        if (bit_last_s) begin
          cnt_s  = {CNT_W{1'b0}};
          done_s = 1'b1;
          // A waiting byte chains straight into the next start bit.
          if (hold_full_r) begin
            take_s  = 1'b1;
            state_s = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase

    if (take_s) begin
      shift_s     = hold_r;
      bit_idx_s   = 3'd0;
      hold_full_s = 1'b0;
    end else if (accept_s) begin
      hold_s      = data_in;
      hold_full_s = 1'b1;
    end else begin
      hold_full_s = hold_full_r;
    end

    // Outputs are computed from next state so the registered copies line up
    // with the state they describe.
    tx_s    = line_level(state_s, shift_s, bit_idx_s);
    busy_s  = (state_s != ST_IDLE) | hold_full_s;
    ready_s = ~hold_full_s;
  end

  // State and output registers with synchronous active-low reset; a reset
  // mid-frame aborts the frame and drops any held byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_idx_r   <= bit_idx_s;
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      tx_r        <= tx_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      ready_r     <= ready_s;
    end
  end

  assign tx    = tx_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign ready = ready_r;

endmodule
